// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX arbiter: FSM state encoding,
// header byte layout, default header tag and datapath widths.
package eth_pkg;

  localparam int unsigned MAX_SRC = 4;   // widest source vector the arbiter supports
  localparam int unsigned GRANT_W = 2;   // width of a source index
  localparam int unsigned CNT_W   = 11;  // payload byte counter width (up to 2047 bytes)
  localparam int unsigned BYTE_W  = 8;

  localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Per-frame header byte sent ahead of every payload.
  typedef struct packed {
    logic [3:0]         tag;
    logic [1:0]         rsvd;
    logic [GRANT_W-1:0] src;
  } hdr_t;

  function automatic logic [BYTE_W-1:0] make_hdr(input logic [3:0]         tag,
                                                 input logic [GRANT_W-1:0] src);
    hdr_t h;
    h.tag  = tag;
    h.rsvd = 2'b00;
    h.src  = src;
    return h;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin requester selection.
// Ports:
//   req        - request vector, one bit per source
//   last_grant - index of the previously granted source
//   grant      - first requester found scanning upward from last_grant+1, wrapping
//   any_req    - at least one request bit is set
module rr_select
  import eth_pkg::*;
#(
  parameter int unsigned NUM_SRC = MAX_SRC
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] grant,
  output logic               any_req
);

  logic [MAX_SRC-1:0] req_pad;
  logic [GRANT_W-1:0] idx;

  // Zero-extend so a 2-bit index is always in range.
  always_comb begin
    req_pad              = '0;
    req_pad[NUM_SRC-1:0] = req;
  end

  // Scan offsets 1..NUM_SRC from the last grant; the first hit wins, so the
  // previous winner is considered last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = GRANT_W'((32'(last_grant) + k) % NUM_SRC);
      if (!any_req && req_pad[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ethernet_tx_arbiter.sv
// Frame-level round-robin arbiter feeding one Ethernet TX controller from
// up to four byte-stream sources. Each granted frame is prefixed with a
// header byte {HDR_TAG, 2'b00, grant_id}; payload bytes pass straight
// through from the granted source. Frames longer than MAX_BYTES are cut
// at MAX_BYTES and the remainder is discarded, setting a sticky error.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   src_data/valid/last - per-source byte stream (source i at byte lane i)
//   src_ready           - per-source accept, only the granted source is readied
//   data/valid/ready    - output byte stream to the TX controller
//   busy                - a frame is in progress (state other than IDLE)
//   grant_id            - current or most recent granted source
//   err_trunc           - sticky, a frame was truncated
module ethernet_tx_arbiter
  import eth_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_BYTES = 1024,
  parameter logic [3:0]  HDR_TAG   = HDR_TAG_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BYTE_W*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [BYTE_W-1:0]         data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      busy,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      err_trunc
);

  state_t                         state;
  logic [CNT_W-1:0]               byte_cnt;
  logic [GRANT_W-1:0]             last_grant;
  logic [GRANT_W-1:0]             rr_grant;
  logic                           rr_any;

  logic [MAX_SRC-1:0][BYTE_W-1:0] data_pad;
  logic [MAX_SRC-1:0]             valid_pad;
  logic [MAX_SRC-1:0]             last_pad;
  logic [MAX_SRC-1:0]             ready_pad;

  logic                           sel_valid;
  logic                           sel_last;
  logic                           pay_xfer;
  logic                           at_limit;

  rr_select #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_select (
    .req        (src_valid),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .any_req    (rr_any)
  );

  // Widen source vectors to the maximum source count for uniform indexing.
  always_comb begin
    data_pad               = '0;
    valid_pad              = '0;
    last_pad               = '0;
    data_pad[NUM_SRC-1:0]  = src_data;
    valid_pad[NUM_SRC-1:0] = src_valid;
    last_pad[NUM_SRC-1:0]  = src_last;
  end

  assign sel_valid = valid_pad[grant_id];
  assign sel_last  = last_pad[grant_id];
  assign pay_xfer  = (state == ST_PAYLOAD) && sel_valid && ready;
  // The transfer in flight is byte number MAX_BYTES of the frame.
  assign at_limit  = (byte_cnt == CNT_W'(MAX_BYTES - 1));

  // Frame sequencing; grant only changes when leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      last_grant <= GRANT_W'(NUM_SRC - 1);
      grant_id   <= '0;
      err_trunc  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr_any) begin
            state      <= ST_HEADER;
            grant_id   <= rr_grant;
            last_grant <= rr_grant;
          end
        end
        ST_HEADER: begin
          if (ready) begin
            state    <= ST_PAYLOAD;
            byte_cnt <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (pay_xfer) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (sel_last) begin
              state <= ST_IDLE;
            end else if (at_limit) begin
              state     <= ST_DRAIN;
              err_trunc <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (sel_valid && sel_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output steering: header from the FSM, payload passed through with no
  // added latency, drained bytes accepted but never presented downstream.
  always_comb begin
    data      = '0;
    valid     = 1'b0;
    ready_pad = '0;
    case (state)
      ST_HEADER: begin
        data  = make_hdr(HDR_TAG, grant_id);
        valid = 1'b1;
      end
      ST_PAYLOAD: begin
        data                = data_pad[grant_id];
        valid               = sel_valid;
        ready_pad[grant_id] = ready;
      end
      ST_DRAIN: begin
        ready_pad[grant_id] = 1'b1;
      end
      default: begin
        data  = '0;
        valid = 1'b0;
      end
    endcase
  end

  assign src_ready = ready_pad[NUM_SRC-1:0];
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Self-checking bench for ethernet_tx_arbiter (4 sources, MAX_BYTES=4).
module tb_ethernet_tx_arbiter;

  localparam int MAXB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0][7:0] sdat;
  logic [3:0]      src_valid;
  logic [3:0]      src_last;
  logic [3:0]      src_ready;
  logic [7:0]      data;
  logic            valid;
  logic            ready;
  logic            busy;
  logic [1:0]      grant_id;
  logic            err_trunc;

  int checks;
  int errors;

  ethernet_tx_arbiter #(
    .NUM_SRC   (4),
    .MAX_BYTES (MAXB),
    .HDR_TAG   (4'hA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_data  (sdat),
    .src_valid (src_valid),
    .src_last  (src_last),
    .src_ready (src_ready),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .grant_id  (grant_id),
    .err_trunc (err_trunc)
  );

  always #5 clk = ~clk;

  // Table vector: inputs for one cycle and the outputs expected in it.
  typedef struct packed {
    logic [3:0] sv;
    logic [1:0] lane;
    logic [7:0] d;
    logic       lst;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic [3:0] e_sr;
    logic       e_busy;
    logic [1:0] e_gid;
  } vec_t;

  typedef struct packed {
    logic       hdr;
    logic [1:0] src;
    logic [7:0] b;
  } exp_t;

  vec_t       vt[$];
  logic [8:0] sq[4][$];   // bytes still to be offered by each source {last, byte}
  logic [8:0] mq[4][$];   // same frames, consumed by the reference model
  bit         fs[4];      // next byte offered by source is a frame's first byte
  exp_t       exp_q[$];
  logic [7:0] obs_hdr[$];
  int         model_last;
  bit         model_err;
  int         out_cnt;
  int         pop_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] sv, input logic [1:0] lane, input logic [7:0] d,
                              input logic lst, input logic rdy, input logic e_valid,
                              input logic [7:0] e_data, input logic [3:0] e_sr,
                              input logic e_busy, input logic [1:0] e_gid);
    vec_t v;
    v.sv = sv; v.lane = lane; v.d = d; v.lst = lst; v.rdy = rdy;
    v.e_valid = e_valid; v.e_data = e_data; v.e_sr = e_sr; v.e_busy = e_busy; v.e_gid = e_gid;
    return v;
  endfunction

  // Present byte d with last flag on one lane; other lanes carry noise.
  task automatic drive_lane(input logic [3:0] sv, input logic [1:0] lane, input logic [7:0] d,
                            input logic lst, input logic rdy);
    for (int i = 0; i < 4; i++) sdat[2'(i)] = 8'($urandom);
    sdat[lane]     = d;
    src_last       = '0;
    src_last[lane] = lst;
    src_valid      = sv;
    ready          = rdy;
  endtask

  task automatic do_reset();
    rst_n     = 1'b1;
    src_valid = '0;
    src_last  = '0;
    ready     = 1'b0;
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sq[i].delete();
      mq[i].delete();
      fs[i] = 1'b1;
    end
    exp_q.delete();
    model_last = 3;
    model_err  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_frame(input int s, input int len);
    logic [8:0] w;
    for (int n = 1; n <= len; n++) begin
      w = {(n == len), 8'($urandom)};
      sq[s].push_back(w);
      mq[s].push_back(w);
    end
  endtask

  // Reference: serve pending frames one at a time in round-robin order, each
  // as a header plus at most MAXB payload bytes.
  task automatic build_expected();
    bit         found;
    int         g;
    int         c;
    int         n;
    logic [8:0] w;
    exp_t       e;
    while (1) begin
      found = 1'b0;
      g     = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (model_last + k) % 4;
        if (!found && mq[c].size() > 0) begin
          found = 1'b1;
          g     = c;
        end
      end
      if (!found) break;
      e.hdr = 1'b1; e.src = 2'(g); e.b = {4'hA, 2'b00, 2'(g)};
      exp_q.push_back(e);
      n = 0;
      do begin
        w = mq[g].pop_front();
        n++;
        if (n <= MAXB) begin
          e.hdr = 1'b0; e.src = 2'(g); e.b = w[7:0];
          exp_q.push_back(e);
        end
        if (n == MAXB && !w[8]) model_err = 1'b1;
      end while (!w[8]);
      model_last = g;
    end
  endtask

  // Play the queued source frames into the DUT and score every output byte.
  task automatic run_frames(input bit rnd, input int budget, input string tag);
    int         cyc;
    bit         done;
    bit         ae;
    logic [8:0] w;
    exp_t       e;
    cyc     = 0;
    done    = 1'b0;
    out_cnt = 0;
    pop_cnt = 0;
    obs_hdr.delete();
    while (!done) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        sdat[2'(i)]      = 8'($urandom);
        src_last[2'(i)]  = 1'b0;
        src_valid[2'(i)] = 1'b0;
        if (sq[i].size() > 0) begin
          w                = sq[i][0];
          src_valid[2'(i)] = fs[i] || !rnd || ($urandom_range(0, 3) != 0);
          sdat[2'(i)]      = w[7:0];
          src_last[2'(i)]  = w[8];
        end
      end
      ready = !rnd || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (valid && ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_extra_byte act=%02h exp=none", tag, data);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, 32'(data), 32'(e.b));
          chk({tag, "_gid"}, 32'(grant_id), 32'(e.src));
          if (e.hdr) obs_hdr.push_back(data);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (src_valid[2'(i)] && src_ready[2'(i)] && sq[i].size() > 0) begin
          w     = sq[i].pop_front();
          fs[i] = w[8];
          pop_cnt++;
        end
      end
      cyc++;
      ae = 1'b1;
      for (int i = 0; i < 4; i++) if (sq[i].size() > 0) ae = 1'b0;
      if (ae && exp_q.size() == 0 && !busy) begin
        done = 1'b1;
      end else if (cyc >= budget) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout act=%0d_bytes_pending exp=0", tag, exp_q.size());
        done = 1'b1;
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    sdat      = '0;
    src_valid = '0;
    src_last  = '0;
    ready     = 1'b0;
    #2;
    // Reset state, with every source requesting.
    rst_n     = 1'b0;
    src_valid = 4'hF;
    ready     = 1'b1;
    #3;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_err", 32'(err_trunc), 32'd0);
    do_reset();

    // Source 1 three-byte frame, then a source 2 frame with ready toggling,
    // a header stall and a mid-frame source stall with another requester.
    vt.push_back(mk(4'b0010, 2'd1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
    vt.push_back(mk(4'b0010, 2'd1, 8'h11, 1'b0, 1'b1, 1'b1, 8'hA1, 4'b0000, 1'b1, 2'd1));
    vt.push_back(mk(4'b0010, 2'd1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 4'b0010, 1'b1, 2'd1));
    vt.push_back(mk(4'b0010, 2'd1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 4'b0010, 1'b1, 2'd1));
    vt.push_back(mk(4'b0010, 2'd1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 4'b0010, 1'b1, 2'd1));
    vt.push_back(mk(4'b0000, 2'd1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1));
    vt.push_back(mk(4'b0100, 2'd2, 8'h51, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1));
    vt.push_back(mk(4'b0100, 2'd2, 8'h51, 1'b0, 1'b0, 1'b1, 8'hA2, 4'b0000, 1'b1, 2'd2));
    vt.push_back(mk(4'b0100, 2'd2, 8'h51, 1'b0, 1'b1, 1'b1, 8'hA2, 4'b0000, 1'b1, 2'd2));
    vt.push_back(mk(4'b0100, 2'd2, 8'h51, 1'b0, 1'b1, 1'b1, 8'h51, 4'b0100, 1'b1, 2'd2));
    vt.push_back(mk(4'b0001, 2'd0, 8'h99, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0100, 1'b1, 2'd2));
    vt.push_back(mk(4'b0100, 2'd2, 8'h52, 1'b0, 1'b0, 1'b1, 8'h52, 4'b0000, 1'b1, 2'd2));
    vt.push_back(mk(4'b0100, 2'd2, 8'h52, 1'b0, 1'b1, 1'b1, 8'h52, 4'b0100, 1'b1, 2'd2));
    vt.push_back(mk(4'b0100, 2'd2, 8'h53, 1'b0, 1'b0, 1'b1, 8'h53, 4'b0000, 1'b1, 2'd2));
    vt.push_back(mk(4'b0100, 2'd2, 8'h53, 1'b0, 1'b1, 1'b1, 8'h53, 4'b0100, 1'b1, 2'd2));
    vt.push_back(mk(4'b0100, 2'd2, 8'h54, 1'b1, 1'b0, 1'b1, 8'h54, 4'b0000, 1'b1, 2'd2));
    vt.push_back(mk(4'b0100, 2'd2, 8'h54, 1'b1, 1'b1, 1'b1, 8'h54, 4'b0100, 1'b1, 2'd2));
    vt.push_back(mk(4'b0000, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2));

    foreach (vt[k]) begin
      @(posedge clk);
      #1;
      drive_lane(vt[k].sv, vt[k].lane, vt[k].d, vt[k].lst, vt[k].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", k), 32'(valid), 32'(vt[k].e_valid));
      if (vt[k].e_valid) chk($sformatf("vec%0d_data", k), 32'(data), 32'(vt[k].e_data));
      chk($sformatf("vec%0d_src_ready", k), 32'(src_ready), 32'(vt[k].e_sr));
      chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(vt[k].e_busy));
      chk($sformatf("vec%0d_gid", k), 32'(grant_id), 32'(vt[k].e_gid));
    end

    // All four sources request together after reset.
    do_reset();
    for (int s = 0; s < 4; s++) load_frame(s, 2);
    build_expected();
    run_frames(1'b0, 200, "rr4");
    chk("rr4_hdr_count", 32'(obs_hdr.size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_hdr.size(); k++)
      chk($sformatf("rr4_hdr%0d", k), 32'(obs_hdr[k]), 32'hA0 + 32'(k));

    // Six-byte frame against a four-byte limit.
    do_reset();
    load_frame(0, 6);
    build_expected();
    run_frames(1'b0, 200, "trunc");
    chk("trunc_out_cnt", 32'(out_cnt), 32'd5);
    chk("trunc_pop_cnt", 32'(pop_cnt), 32'd6);
    chk("trunc_err", 32'(err_trunc), 32'd1);
    chk("trunc_busy", 32'(busy), 32'd0);

    // Frame of exactly the limit ends normally.
    do_reset();
    load_frame(2, 4);
    build_expected();
    run_frames(1'b0, 200, "exact");
    chk("exact_out_cnt", 32'(out_cnt), 32'd5);
    chk("exact_err", 32'(err_trunc), 32'd0);

    // Reset while payload byte 2 is presented.
    do_reset();
    @(posedge clk); #1; drive_lane(4'b0010, 2'd1, 8'h71, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; drive_lane(4'b0010, 2'd1, 8'h72, 1'b0, 1'b1);
    #1;
    chk("mid_rst_pre_valid", 32'(valid), 32'd1);
    chk("mid_rst_pre_data", 32'(data), 32'h72);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_src_ready", 32'(src_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    drive_lane(4'b0101, 2'd0, 8'h5A, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_hdr", 32'(data), 32'hA0);
    chk("post_rst_gid", 32'(grant_id), 32'd0);

    // Randomized frames, gaps and back-pressure against the reference model.
    do_reset();
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < 4; s++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) load_frame(s, $urandom_range(1, 7));
      end
      build_expected();
      run_frames(1'b1, 3000, $sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_err", it), 32'(err_trunc), 32'(model_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ethernet_tx_arbiter.md
ETHERNET_TX_ARBITER -- requirements
Module: ethernet_tx_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of frame sources (2..4).
REQ-002 Parameter MAX_BYTES, default 1024, maximum payload bytes per frame (2..2047).
REQ-003 Parameter HDR_TAG, default 4'hA, upper nibble of the per-frame header byte.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 src_data  in  8*NUM_SRC  payload byte per source; source i occupies bits [8i+7:8i].
REQ-007 src_valid  in  NUM_SRC  source i presents a byte.
REQ-008 src_last  in  NUM_SRC  byte presented by source i ends its frame.
REQ-009 src_ready  out  NUM_SRC  source i byte accepted when src_valid[i] & src_ready[i].
REQ-010 data  out  8  byte to the Ethernet TX controller.
REQ-011 valid  out  1  data is valid.
REQ-012 ready  in  1  TX controller accepts; a transfer occurs when valid & ready.
REQ-013 busy  out  1  a frame is granted (state other than IDLE).
REQ-014 grant_id  out  2  index of the currently or most recently granted source.
REQ-015 err_trunc  out  1  sticky: at least one frame was truncated at MAX_BYTES.

Function
REQ-016 States SHALL be IDLE, HEADER, PAYLOAD, DRAIN.
REQ-017 IDLE: valid=0, src_ready=0; if any src_valid set, next cycle SHALL be HEADER with grant = first requester scanning from (last_grant+1) mod NUM_SRC upward, wrapping (round-robin).
REQ-018 A source SHALL only be granted at a frame boundary; grant SHALL never change during HEADER, PAYLOAD or DRAIN.
REQ-019 HEADER: valid=1, data={HDR_TAG, 2'b00, grant_id}, all src_ready=0; on ready SHALL go to PAYLOAD.
REQ-020 PAYLOAD: data=src_data[grant], valid=src_valid[grant], src_ready[grant]=ready, other src_ready=0 (combinational pass-through, zero added latency).
REQ-021 PAYLOAD: 11-bit byte counter SHALL clear on HEADER exit and increment on each payload transfer.
REQ-022 PAYLOAD transfer with src_last=1 SHALL return to IDLE next cycle.
REQ-023 PAYLOAD transfer that is byte number MAX_BYTES with src_last=0 SHALL set err_trunc and go to DRAIN.
REQ-024 Transfer that is byte MAX_BYTES with src_last=1 SHALL NOT truncate; return to IDLE.
REQ-025 DRAIN: valid=0, src_ready[grant]=1; source bytes discarded; accepted byte with src_last=1 SHALL return to IDLE.
REQ-026 Source deasserting src_valid mid-frame SHALL stall the frame (no timeout, no regrant).
REQ-027 Simultaneous requests in IDLE SHALL be served one frame each in round-robin order before any source is served twice.
REQ-028 Minimum gap: one IDLE cycle between frames; throughput otherwise one byte per cycle while ready=1.
REQ-029 busy SHALL be combinationally (state != IDLE); grant_id, err_trunc registered.

Reset
REQ-030 On rst_n low, state=IDLE, counter=0, last_grant=NUM_SRC-1 (so source 0 wins first), grant_id=0, err_trunc=0, valid=0, src_ready=0, busy=0.
REQ-031 Reset mid-frame SHALL abort immediately; partial frame is not completed; after release arbitration restarts from source 0.
REQ-032 err_trunc SHALL clear only on reset.

Structure
REQ-033 State encoding, header tag default and counter width SHALL live in shared package eth_pkg.
REQ-034 Round-robin selection SHALL be a sub-module rr_select (request vector, last grant in; grant index, any-request out).

Verification
REQ-035 Source 1 only, 3-byte frame 11,22,33 last, ready=1 -> output A1,11,22,33; busy 4 cycles; grant_id=1.
REQ-036 All 4 sources request simultaneously after reset -> frames served in order 0,1,2,3, headers A0,A1,A2,A3.
REQ-037 ready toggles 1,0,1,0 during 4-byte frame -> each byte held stable while ready=0; no byte lost or duplicated; src_ready mirrors ready.
REQ-038 MAX_BYTES=4, source sends 6 bytes -> header + 4 payload bytes output, bytes 5,6 drained with valid=0, err_trunc=1, then IDLE.
REQ-039 MAX_BYTES=4, exactly 4 bytes with last on byte 4 -> no truncation, err_trunc stays 0.
REQ-040 rst_n asserted during PAYLOAD byte 2 -> valid=0, src_ready=0, busy=0 same cycle; next request after release granted to source 0.
